tlb_assoc: RTL and testbench

- Parametrised, fully associative TLB; successor to the fixed 8-entry TLB.
- Sits between the fetch/memory stages and physical memory.
- Translates two lookup ports: port 0 for fetch and port 1 for memory.
- Also provides a key-addressed read-back port, a write/refill port, global clear, and a multi-cycle flush-by-PID engine.

---
 rtl/tlb_assoc_if.sv | 56 +++++
 rtl/tlb_assoc.sv | 204 ++++++++++++++++++++
 tb/tb_tlb_assoc.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_assoc_if.sv
// tlb_assoc_if: request/response bundle between the pipeline and the TLB.
// Define TLB_STATS_EN to add the hit/miss counter signals.
interface tlb_assoc_if #(
  parameter int PID_W     = 12,
  parameter int VA_W      = 32,
  parameter int PAGE_BITS = 12,
  parameter int PPN_W     = 6
);
  localparam int VPN_W = VA_W - PAGE_BITS;
  localparam int KEY_W = PID_W + VPN_W;
  localparam int PA_W  = PPN_W + PAGE_BITS;

  logic             kmode;
  logic [PID_W-1:0] pid;
  logic [VA_W-1:0]  addr0;
  logic [VA_W-1:0]  addr1;
  logic [7:0]       exc_in;
  logic             we;
  logic [KEY_W-1:0] wkey;
  logic [PPN_W-1:0] wdata;
  logic             clear;
  logic             flush_req;
  logic [PID_W-1:0] flush_pid;
  logic [7:0]       exc_out0;
  logic [7:0]       exc_out1;
  logic [PA_W-1:0]  addr0_out;
  logic [PA_W-1:0]  addr1_out;
  logic [PPN_W-1:0] rd_ppn;
  logic             rd_hit;
  logic             flush_busy;
  logic             flush_done;
`ifdef TLB_STATS_EN
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;

  modport master (
    output kmode, pid, addr0, addr1, exc_in, we, wkey, wdata, clear, flush_req, flush_pid,
    input  exc_out0, exc_out1, addr0_out, addr1_out, rd_ppn, rd_hit, flush_busy, flush_done,
           hit_cnt, miss_cnt
  );
  modport slave (
    input  kmode, pid, addr0, addr1, exc_in, we, wkey, wdata, clear, flush_req, flush_pid,
    output exc_out0, exc_out1, addr0_out, addr1_out, rd_ppn, rd_hit, flush_busy, flush_done,
           hit_cnt, miss_cnt
  );
`else
  modport master (
    output kmode, pid, addr0, addr1, exc_in, we, wkey, wdata, clear, flush_req, flush_pid,
    input  exc_out0, exc_out1, addr0_out, addr1_out, rd_ppn, rd_hit, flush_busy, flush_done
  );
  modport slave (
    input  kmode, pid, addr0, addr1, exc_in, we, wkey, wdata, clear, flush_req, flush_pid,
    output exc_out0, exc_out1, addr0_out, addr1_out, rd_ppn, rd_hit, flush_busy, flush_done
  );
`endif
endinterface

// File: rtl/tlb_assoc.sv
// tlb_assoc: fully associative TLB with two translate ports, key read-back, refill,
// clear and a flush-by-PID walker. Define TLB_STATS_EN to add saturating hit/miss counters.
module tlb_assoc #(
  parameter int          ENTRIES       = 8,
  parameter int          PID_W         = 12,
  parameter int          VA_W          = 32,
  parameter int          PAGE_BITS     = 12,
  parameter int          PPN_W         = 6,
  parameter logic [31:0] KBYPASS_LIMIT = 32'h30000
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clk_en,
  tlb_assoc_if.slave  bus
);
  localparam int VPN_W = VA_W - PAGE_BITS;
  localparam int KEY_W = PID_W + VPN_W;
  localparam int PA_W  = PPN_W + PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [VA_W-1:0]  BYPASS_LIM = VA_W'(KBYPASS_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, WALK} state_t;

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][KEY_W-1:0] key_q, key_d;
  logic [ENTRIES-1:0][PPN_W-1:0] ppn_q, ppn_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [PID_W-1:0]              fpid_q, fpid_d;
  logic                          done_q, done_d;
  state_t                        state_q, state_d;

  // Lowest-indexed valid match wins: scan downward so the last hit assigned is the lowest.
  function automatic logic [IDX_W:0] find_key(input logic [KEY_W-1:0] k,
                                              input logic [ENTRIES-1:0] v,
                                              input logic [ENTRIES-1:0][KEY_W-1:0] keys);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (v[i] && keys[i] == k) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  function automatic logic [IDX_W:0] find_free(input logic [ENTRIES-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!v[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  logic [KEY_W-1:0] key0, key1;
  logic [IDX_W:0]   m0, m1, mr, fr;
  logic             hit0, hit1, bypass0, bypass1;
  logic [PPN_W-1:0] ppn0, ppn1;
  logic [7:0]       miss_code, exc0, exc1;

  assign key0      = {bus.pid, bus.addr0[VA_W-1:PAGE_BITS]};
  assign key1      = {bus.pid, bus.addr1[VA_W-1:PAGE_BITS]};
  assign m0        = find_key(key0, valid_q, key_q);
  assign m1        = find_key(key1, valid_q, key_q);
  assign mr        = find_key(bus.wkey, valid_q, key_q);
  assign fr        = find_free(valid_q);
  assign hit0      = m0[IDX_W];
  assign hit1      = m1[IDX_W];
  assign ppn0      = ppn_q[m0[IDX_W-1:0]];
  assign ppn1      = ppn_q[m1[IDX_W-1:0]];
  assign bypass0   = bus.kmode && (bus.addr0 < BYPASS_LIM);
  assign bypass1   = bus.kmode && (bus.addr1 < BYPASS_LIM);
  assign miss_code = bus.kmode ? 8'h83 : 8'h82;
  assign exc0      = (!hit0 && !bypass0) ? miss_code : 8'h00;
  assign exc1      = (bus.exc_in != 8'h00) ? bus.exc_in :
                     ((!hit1 && !bypass1) ? miss_code : 8'h00);

  always_comb begin
    bus.exc_out0 = exc0;
    bus.exc_out1 = exc1;
    bus.rd_hit   = mr[IDX_W];
    bus.rd_ppn   = mr[IDX_W] ? ppn_q[mr[IDX_W-1:0]] : '0;
    bus.flush_busy = (state_q == WALK);
    bus.flush_done = done_q;
    if (bypass0)     bus.addr0_out = bus.addr0[PA_W-1:0];
    else if (hit0)   bus.addr0_out = {ppn0, bus.addr0[PAGE_BITS-1:0]};
    else             bus.addr0_out = '0;
    // Bypass wins over an upstream exception; otherwise any exception redirects to its vector.
    if (bypass1)             bus.addr1_out = bus.addr1[PA_W-1:0];
    else if (exc1 != 8'h00)  bus.addr1_out = PA_W'({exc1, 2'b00});
    else                     bus.addr1_out = {ppn1, bus.addr1[PAGE_BITS-1:0]};
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    ppn_d   = ppn_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    fpid_d  = fpid_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (clk_en) begin
      if (bus.clear) begin
        valid_d = '0;
        ptr_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.flush_req) begin
              state_d = WALK;
              idx_d   = '0;
              fpid_d  = bus.flush_pid;
            end
            // Refill: overwrite a matching key, else fill the lowest hole, else evict round-robin.
            if (bus.we) begin
              if (mr[IDX_W]) begin
                ppn_d[mr[IDX_W-1:0]] = bus.wdata;
              end else if (fr[IDX_W]) begin
                valid_d[fr[IDX_W-1:0]] = 1'b1;
                key_d[fr[IDX_W-1:0]]   = bus.wkey;
                ppn_d[fr[IDX_W-1:0]]   = bus.wdata;
              end else begin
                key_d[ptr_q] = bus.wkey;
                ppn_d[ptr_q] = bus.wdata;
                ptr_d        = ptr_q + IDX_W'(1);
              end
            end
          end
          WALK: begin
            if (valid_q[idx_q] && key_q[idx_q][KEY_W-1:VPN_W] == fpid_q)
              valid_d[idx_q] = 1'b0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      key_q   <= '0;
      ppn_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      fpid_q  <= '0;
      done_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      ppn_q   <= ppn_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      fpid_q  <= fpid_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

`ifdef TLB_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + {31'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        cnt0, cnt1;
  logic [1:0]  hit_inc, miss_inc;

  assign cnt0     = !bypass0 && (bus.exc_in == 8'h00);
  assign cnt1     = !bypass1 && (bus.exc_in == 8'h00);
  assign hit_inc  = {1'b0, cnt0 && hit0} + {1'b0, cnt1 && hit1};
  assign miss_inc = {1'b0, cnt0 && !hit0} + {1'b0, cnt1 && !hit1};
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clk_en) begin
      hit_cnt_d  = sat_add(hit_cnt_q, hit_inc);
      miss_cnt_d = sat_add(miss_cnt_q, miss_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: directed scoreboard bench for tlb_assoc (default 8-entry configuration).
module tb_tlb_assoc;
  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles;
  int   done_pulses;

  tlb_assoc_if bus ();

  tlb_assoc u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic km, input logic [11:0] p, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [7:0] ei);
    bus.kmode  = km;
    bus.pid    = p;
    bus.addr0  = a0;
    bus.addr1  = a1;
    bus.exc_in = ei;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed %0h, expected an entry", actual);
    end else begin
      e = exp_q.pop_front();
      assert (actual === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, actual, e.val);
      end
    end
  endtask

  task automatic do_write(input logic [11:0] p, input logic [19:0] vpn, input logic [5:0] ppn);
    bus.wkey  = {p, vpn};
    bus.wdata = ppn;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic readback(input string tag, input logic [11:0] p, input logic [19:0] vpn,
                          input logic hit, input logic [5:0] ppn);
    bus.wkey = {p, vpn};
    push_exp({tag, "_hit"}, {31'b0, hit});
    push_exp({tag, "_ppn"}, {26'b0, ppn});
    #1;
    checkOutput({31'b0, bus.rd_hit});
    checkOutput({26'b0, bus.rd_ppn});
  endtask

  initial begin
    rst_n         = 1'b0;
    clk_en        = 1'b1;
    bus.we        = 1'b0;
    bus.wkey      = '0;
    bus.wdata     = '0;
    bus.clear     = 1'b0;
    bus.flush_req = 1'b0;
    bus.flush_pid = '0;
    applyStimulus(1'b0, 12'h001, 32'h0, 32'h0, 8'h00);

    // Reset state
    push_exp("rst_busy", 32'h0);
    push_exp("rst_done", 32'h0);
    push_exp("rst_exc0", 32'h82);
    #1;
    checkOutput({31'b0, bus.flush_busy});
    checkOutput({31'b0, bus.flush_done});
    checkOutput({24'b0, bus.exc_out0});
    readback("rst_rd", 12'h001, 20'h00005, 1'b0, 6'h00);
    #2 rst_n = 1'b1;
    tick();

    // Empty-table misses and kernel bypass
    applyStimulus(1'b0, 12'h001, 32'h00005ABC, 32'h0, 8'h00);
    push_exp("miss_user_exc0", 32'h82);
    #1 checkOutput({24'b0, bus.exc_out0});
    applyStimulus(1'b1, 12'h001, 32'h00040000, 32'h0, 8'h00);
    push_exp("miss_kern_exc0", 32'h83);
    #1 checkOutput({24'b0, bus.exc_out0});
    applyStimulus(1'b1, 12'h001, 32'h0001FFFC, 32'h0, 8'h00);
    push_exp("bypass_addr0", 32'h1FFFC);
    push_exp("bypass_exc0", 32'h0);
    #1;
    checkOutput({14'b0, bus.addr0_out});
    checkOutput({24'b0, bus.exc_out0});

    // Single refill and translation
    do_write(12'h001, 20'h00005, 6'h2A);
    applyStimulus(1'b0, 12'h001, 32'h00005123, 32'h00005ABC, 8'h00);
    push_exp("hit_addr1", 32'h2AABC);
    push_exp("hit_exc1", 32'h0);
    push_exp("hit_addr0", 32'h2A123);
    #1;
    checkOutput({14'b0, bus.addr1_out});
    checkOutput({24'b0, bus.exc_out1});
    checkOutput({14'b0, bus.addr0_out});
    applyStimulus(1'b0, 12'h001, 32'h00005123, 32'h00005ABC, 8'h10);
    push_exp("excin_exc1", 32'h10);
    push_exp("excin_addr1", 32'h40);
    #1;
    checkOutput({24'b0, bus.exc_out1});
    checkOutput({14'b0, bus.addr1_out});
    applyStimulus(1'b0, 12'h002, 32'h00005123, 32'h00005ABC, 8'h00);
    push_exp("wrong_pid_exc1", 32'h82);
    push_exp("wrong_pid_addr1", 32'h208);
    #1;
    checkOutput({24'b0, bus.exc_out1});
    checkOutput({14'b0, bus.addr1_out});
    applyStimulus(1'b1, 12'h001, 32'h0, 32'h00001234, 8'h10);
    push_exp("bypass1_exc1", 32'h10);
    push_exp("bypass1_addr1", 32'h01234);
    #1;
    checkOutput({24'b0, bus.exc_out1});
    checkOutput({14'b0, bus.addr1_out});
    readback("rb_single", 12'h001, 20'h00005, 1'b1, 6'h2A);

    // Fill, round-robin eviction and in-place rewrite
    do_clear();
    for (int i = 0; i < 8; i++) do_write(12'h001, 20'h00100 + 20'(i), 6'(i + 1));
    do_write(12'h001, 20'h00200, 6'h3F);
    do_write(12'h001, 20'h00103, 6'h11);
    readback("rewrite_k3", 12'h001, 20'h00103, 1'b1, 6'h11);
    do_write(12'h001, 20'h00201, 6'h22);
    readback("evict_e0", 12'h001, 20'h00100, 1'b0, 6'h00);
    readback("evict_e1", 12'h001, 20'h00101, 1'b0, 6'h00);
    readback("keep_e2", 12'h001, 20'h00102, 1'b1, 6'h03);
    readback("keep_k3", 12'h001, 20'h00103, 1'b1, 6'h11);
    readback("new_200", 12'h001, 20'h00200, 1'b1, 6'h3F);
    readback("new_201", 12'h001, 20'h00201, 1'b1, 6'h22);
    applyStimulus(1'b0, 12'h001, 32'h00103456, 32'h00104010, 8'h00);
    push_exp("full_addr0", 32'h11456);
    push_exp("full_addr1", 32'h05010);
    #1;
    checkOutput({14'b0, bus.addr0_out});
    checkOutput({14'b0, bus.addr1_out});

    // Flush by PID with a blocked write in the middle
    do_clear();
    do_write(12'h001, 20'h00010, 6'h01);
    do_write(12'h002, 20'h00011, 6'h02);
    do_write(12'h001, 20'h00012, 6'h03);
    do_write(12'h002, 20'h00013, 6'h04);
    bus.flush_pid = 12'h001;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.flush_busy) busy_cycles++;
      if (bus.flush_done) done_pulses++;
      if (c == 3) begin
        bus.wkey  = {12'h003, 20'h00050};
        bus.wdata = 6'h09;
        bus.we    = 1'b1;
      end
      if (c == 4) bus.we = 1'b0;
      tick();
    end
    push_exp("flush_busy_cycles", 32'd8);
    push_exp("flush_done_pulses", 32'd1);
    checkOutput(32'(busy_cycles));
    checkOutput(32'(done_pulses));
    readback("fl_pid1_a", 12'h001, 20'h00010, 1'b0, 6'h00);
    readback("fl_pid2_a", 12'h002, 20'h00011, 1'b1, 6'h02);
    readback("fl_pid1_b", 12'h001, 20'h00012, 1'b0, 6'h00);
    readback("fl_pid2_b", 12'h002, 20'h00013, 1'b1, 6'h04);
    readback("fl_we_blocked", 12'h003, 20'h00050, 1'b0, 6'h00);

    // Clear together with we in the middle of a flush
    bus.flush_pid = 12'h002;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    tick();
    bus.wkey  = {12'h005, 20'h00077};
    bus.wdata = 6'h15;
    bus.we    = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.clear = 1'b0;
    push_exp("clr_busy", 32'h0);
    #1 checkOutput({31'b0, bus.flush_busy});
    readback("clr_pid2", 12'h002, 20'h00013, 1'b0, 6'h00);
    readback("clr_we", 12'h005, 20'h00077, 1'b0, 6'h00);
    done_pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.flush_done) done_pulses++;
      tick();
    end
    push_exp("clr_no_done", 32'd0);
    checkOutput(32'(done_pulses));

    // Asynchronous reset in the middle of a flush
    do_write(12'h002, 20'h00011, 6'h05);
    readback("pre_rst", 12'h002, 20'h00011, 1'b1, 6'h05);
    bus.flush_pid = 12'h007;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    rst_n = 1'b0;
    push_exp("arst_busy", 32'h0);
    #1 checkOutput({31'b0, bus.flush_busy});
    readback("arst_table", 12'h002, 20'h00011, 1'b0, 6'h00);
    rst_n = 1'b1;
    done_pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.flush_done) done_pulses++;
    end
    push_exp("arst_no_done", 32'd0);
    checkOutput(32'(done_pulses));

    // Stall: a write with clk_en low must not land
    clk_en = 1'b0;
    do_write(12'h001, 20'h00033, 6'h07);
    clk_en = 1'b1;
    readback("stall_we", 12'h001, 20'h00033, 1'b0, 6'h00);

`ifdef TLB_STATS_EN
    // Counters: fresh reset, set up with both ports bypassed so setup cycles do not count
    applyStimulus(1'b1, 12'h001, 32'h0, 32'h0, 8'h00);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    push_exp("cnt_rst_hit", 32'd0);
    push_exp("cnt_rst_miss", 32'd0);
    #1;
    checkOutput(bus.hit_cnt);
    checkOutput(bus.miss_cnt);
    do_write(12'h001, 20'h00005, 6'h2A);
    applyStimulus(1'b0, 12'h001, 32'h00005ABC, 32'h00009000, 8'h00);
    tick();
    tick();
    tick();
    push_exp("cnt3_hit", 32'd3);
    push_exp("cnt3_miss", 32'd3);
    checkOutput(bus.hit_cnt);
    checkOutput(bus.miss_cnt);
    clk_en = 1'b0;
    tick();
    tick();
    push_exp("cnt_stall_hit", 32'd3);
    push_exp("cnt_stall_miss", 32'd3);
    checkOutput(bus.hit_cnt);
    checkOutput(bus.miss_cnt);
    clk_en = 1'b1;
    applyStimulus(1'b0, 12'h001, 32'h00005ABC, 32'h00005000, 8'h00);
    tick();
    push_exp("cnt_dual_hit", 32'd5);
    checkOutput(bus.hit_cnt);
    applyStimulus(1'b0, 12'h001, 32'h00005ABC, 32'h00009000, 8'h10);
    tick();
    push_exp("cnt_excin_hit", 32'd5);
    push_exp("cnt_excin_miss", 32'd3);
    checkOutput(bus.hit_cnt);
    checkOutput(bus.miss_cnt);
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
